// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 master that streams a block out of a NOR flash
// using Fast Read (0x0B, one bit per SCK) or Dual Output Fast Read (0x3B, two
// bits per SCK). Read bytes leave through a valid/ready stream. SCK is held
// low before the edge that would overwrite an unconsumed byte.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter bit          DUAL    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi_o,
  output logic        spi_mosi_oe,
  input  logic        spi_mosi_i,
  input  logic        spi_miso_i
);

  localparam logic [7:0] OPCODE        = DUAL ? 8'h3B : 8'h0B;
  localparam logic [4:0] BITS_PER_BYTE = DUAL ? 5'd4 : 5'd8;
  localparam logic [8:0] HALF_RELOAD   = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_RELOAD    = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;

  state_t      state;
  logic [8:0]  half_cnt;   // clk cycles left in the current SCK half-period
  logic [4:0]  bit_cnt;    // rising edges left in the phase (DATA: in the byte)
  logic [15:0] byte_cnt;   // bytes still to be received
  logic [30:0] tx_sr;      // opcode[6:0] and address still to be shifted out
  logic [6:0]  rx_sr;      // partially assembled byte

  logic       tick;
  logic       accept;
  logic       byte_last_bit;
  logic       stall;
  logic [7:0] rx_next;

  assign tick          = (half_cnt == 9'd0);
  assign accept        = start && !busy;
  assign byte_last_bit = (bit_cnt == 5'd1);
  // Completing a byte while the previous one is still unconsumed would lose it
  assign stall         = byte_last_bit && rd_valid && !rd_ready;
  assign rx_next       = DUAL ? {rx_sr[5:0], spi_miso_i, spi_mosi_i}
                              : {rx_sr[6:0], spi_miso_i};

  // Transaction sequencer: SCK generation, shifting, output stream and status
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      spi_csn     <= 1'b1;
      spi_sck     <= 1'b0;
      spi_mosi_o  <= 1'b0;
      spi_mosi_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      if (state != IDLE) half_cnt <= tick ? HALF_RELOAD : half_cnt - 9'd1;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (accept) begin
            busy <= 1'b1;
            if (len == 16'd0) begin
              done <= 1'b1;
            end else begin
              state       <= CMD;
              spi_csn     <= 1'b0;
              spi_mosi_oe <= 1'b1;
              spi_mosi_o  <= OPCODE[7];
              tx_sr       <= {OPCODE[6:0], addr};
              bit_cnt     <= 5'd8;
              byte_cnt    <= len;
              half_cnt    <= HALF_RELOAD;
            end
          end
        end

        CMD, ADDR, DUMMY: begin
          if (tick) begin
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              bit_cnt <= bit_cnt - 5'd1;
            end else begin
              spi_sck <= 1'b0;
              // MOSI only moves on the falling edge so the flash sees stable data
              if (state != DUMMY) begin
                tx_sr      <= {tx_sr[29:0], 1'b0};
                spi_mosi_o <= tx_sr[30];
              end
              if (bit_cnt == 5'd0) begin
                case (state)
                  CMD: begin
                    state   <= ADDR;
                    bit_cnt <= 5'd24;
                  end
                  ADDR: begin
                    // Release IO0 for the whole dummy phase before the flash drives it
                    state       <= DUMMY;
                    bit_cnt     <= 5'd8;
                    spi_mosi_oe <= 1'b0;
                    spi_mosi_o  <= 1'b0;
                  end
                  default: begin
                    state   <= DATA;
                    bit_cnt <= BITS_PER_BYTE;
                  end
                endcase
              end
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (!spi_sck) begin
              // A stalled edge is simply retried at the next half-period expiry
              if (!stall) begin
                spi_sck <= 1'b1;
                rx_sr   <= rx_next[6:0];
                if (byte_last_bit) begin
                  rd_data  <= rx_next;
                  rd_valid <= 1'b1;
                  byte_cnt <= byte_cnt - 16'd1;
                  bit_cnt  <= BITS_PER_BYTE;
                end else begin
                  bit_cnt <= bit_cnt - 5'd1;
                end
              end
            end else begin
              spi_sck <= 1'b0;
              if (byte_cnt == 16'd0) state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (tick) begin
            state    <= GAP;
            spi_csn  <= 1'b1;
            done     <= 1'b1;
            half_cnt <= GAP_RELOAD;
          end
        end

        GAP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a dual-mode instance (CLK_DIV=2) and a
// single-mode instance (CLK_DIV=3) share one flash model and one scoreboard
// through a selector; only the selected instance is ever started.
`timescale 1ns/1ps
module tb_spi_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start, rd_ready, sel, rdy_rand;
  logic [23:0] addr;
  logic [15:0] len;
  logic        start0, start1;
  logic        busy0, busy1, done0, done1, rv0, rv1;
  logic [7:0]  rd0, rd1;
  logic        csn0, csn1, sck0, sck1, mo0, mo1, oe0, oe1;
  logic        miso = 1'b0;
  logic        flash_io0 = 1'b0;
  logic        flash_drive = 1'b0;
  logic        mosi_pad;

  logic        busy_m, done_m, rv_m, csn_m, sck_m, mo_m, oe_m;
  logic [7:0]  rd_m;

  assign start0   = start & ~sel;
  assign start1   = start & sel;
  assign busy_m   = sel ? busy1 : busy0;
  assign done_m   = sel ? done1 : done0;
  assign rv_m     = sel ? rv1   : rv0;
  assign rd_m     = sel ? rd1   : rd0;
  assign csn_m    = sel ? csn1  : csn0;
  assign sck_m    = sel ? sck1  : sck0;
  assign mo_m     = sel ? mo1   : mo0;
  assign oe_m     = sel ? oe1   : oe0;
  assign mosi_pad = flash_drive ? flash_io0 : mo_m;

  spi_flash_reader #(.CLK_DIV(2), .DUAL(1'b1)) dut_dual (
    .clk(clk), .resetn(resetn), .start(start0), .addr(addr), .len(len),
    .busy(busy0), .done(done0), .rd_data(rd0), .rd_valid(rv0), .rd_ready(rd_ready),
    .spi_csn(csn0), .spi_sck(sck0), .spi_mosi_o(mo0), .spi_mosi_oe(oe0),
    .spi_mosi_i(mosi_pad), .spi_miso_i(miso));

  spi_flash_reader #(.CLK_DIV(3), .DUAL(1'b0)) dut_single (
    .clk(clk), .resetn(resetn), .start(start1), .addr(addr), .len(len),
    .busy(busy1), .done(done1), .rd_data(rd1), .rd_valid(rv1), .rd_ready(rd_ready),
    .spi_csn(csn1), .spi_sck(sck1), .spi_mosi_o(mo1), .spi_mosi_oe(oe1),
    .spi_mosi_i(mosi_pad), .spi_miso_i(miso));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash contents: fixed bytes where named tests read, a hash elsewhere
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h030000: return 8'hA5;
      24'h030001: return 8'h3C;
      24'h030002: return 8'h0F;
      24'h030003: return 8'hF0;
      24'h050010: return 8'h12;
      24'h050011: return 8'h34;
      default:    return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  // Flash model: mode 0, captures opcode/address on rising edges, drives data after falling edges
  int          f_rise = 0;
  logic [7:0]  f_cmd = 8'h00;
  logic [23:0] f_addr = 24'h0;

  always @(negedge csn_m) begin
    f_rise = 0;
    f_cmd  = 8'h00;
    f_addr = 24'h0;
  end
  always @(posedge csn_m) flash_drive = 1'b0;

  always @(posedge sck_m) begin
    if (!csn_m) begin
      if (f_rise < 8) f_cmd = {f_cmd[6:0], mo_m};
      else if (f_rise < 32) f_addr = {f_addr[22:0], mo_m};
      f_rise = f_rise + 1;
    end
  end

  always @(negedge sck_m) begin
    if (!csn_m && f_rise >= 40) begin
      int k;
      logic [7:0] b;
      k = f_rise - 40;
      if (f_cmd == 8'h3B) begin
        b = flash_byte(f_addr + 24'(k / 4));
        miso        = b[7 - 2 * (k % 4)];
        flash_io0   = b[6 - 2 * (k % 4)];
        flash_drive = 1'b1;
      end else begin
        b    = flash_byte(f_addr + 24'(k / 8));
        miso = b[7 - (k % 8)];
      end
    end
  end

  // Monitor: edge timing, done pulses, contention and scoreboard pops
  logic [7:0] exp_q[$];
  int rises, t_first_rise, t_last_rise, t_csn_fall, t_done, t_busy_fall;
  int done_cnt, csn_low, contention = 0;
  logic prev_sck = 1'b0, prev_csn = 1'b1, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (resetn) begin
      if (sck_m && !prev_sck) begin
        rises++;
        if (rises == 1) t_first_rise = cyc;
        t_last_rise = cyc;
      end
      if (!csn_m && prev_csn) t_csn_fall = cyc;
      if (!csn_m) csn_low++;
      if (done_m) begin
        done_cnt++;
        t_done = cyc;
      end
      if (!busy_m && prev_busy) t_busy_fall = cyc;
      if (flash_drive && oe_m) contention++;
      if (rv_m && rd_ready) begin
        check("rd_byte_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("rd_data", rd_m, exp_q.pop_front());
      end
    end
    prev_sck  = sck_m;
    prev_csn  = csn_m;
    prev_busy = busy_m;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_mon();
    rises = 0; done_cnt = 0; csn_low = 0;
    t_first_rise = -1; t_last_rise = -1; t_csn_fall = -1; t_done = -1; t_busy_fall = -1;
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [15:0] n, input bit extra_start, input bit bp);
    int T, bpb, cd, lim;
    logic [7:0] op;
    bpb = sel ? 8 : 4;
    cd  = sel ? 3 : 2;
    op  = sel ? 8'h0B : 8'h3B;
    clear_mon();
    for (int i = 0; i < int'(n); i++) exp_q.push_back(flash_byte(a + 24'(i)));
    if (bp) rd_ready = 1'b0;
    addr = a; len = n; start = 1'b1; T = cyc;
    tick();
    start = 1'b0;
    if (extra_start) begin
      repeat (5) tick();
      addr = a ^ 24'hFFFFFF; len = 16'd7; start = 1'b1;
      tick();
      start = 1'b0; addr = a; len = n;
    end
    if (bp) begin
      lim = 0;
      while (!rv_m && lim < 2000) begin tick(); lim++; end
      repeat (20) tick();
      check("bp_rises_while_stalled", rises, 47);
      check("bp_sck_low_while_stalled", sck_m, 0);
      rd_ready = 1'b1;
    end
    lim = 0;
    while (done_cnt == 0 && lim < 20000) begin tick(); lim++; end
    lim = 0;
    while ((busy_m || exp_q.size() != 0) && lim < 20000) begin tick(); lim++; end
    repeat (3) tick();
    check("opcode", f_cmd, op);
    check("address", f_addr, a);
    check("sck_rises", rises, 40 + bpb * int'(n));
    check("csn_fall_cycle", t_csn_fall, T + 1);
    check("first_rise_cycle", t_first_rise, T + 1 + cd);
    check("done_after_last_rise", t_done - t_last_rise, 2 * cd);
    check("busy_fall_after_done", t_busy_fall - t_done, 2 * cd);
    check("done_count", done_cnt, 1);
    check("bytes_outstanding", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_csn"},      csn_m, 1);
    check({tag, "_sck"},      sck_m, 0);
    check({tag, "_mosi_o"},   mo_m, 0);
    check({tag, "_mosi_oe"},  oe_m, 0);
    check({tag, "_busy"},     busy_m, 0);
    check({tag, "_done"},     done_m, 0);
    check({tag, "_rd_valid"}, rv_m, 0);
    check({tag, "_rd_data"},  rd_m, 0);
  endtask

  initial begin
    int lim, T;
    resetn = 1'b0; start = 1'b0; addr = '0; len = '0;
    rd_ready = 1'b1; sel = 1'b0; rdy_rand = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    resetn = 1'b1;
    tick(); tick();

    run_txn(24'h030000, 16'd4, 1'b0, 1'b0);
    run_txn(24'h001234, 16'd3, 1'b1, 1'b0);
    run_txn(24'h0A0B0C, 16'd3, 1'b0, 1'b1);

    // Zero-length request: no bus activity, one-cycle busy and done
    clear_mon();
    addr = 24'h123456; len = 16'd0; start = 1'b1; T = cyc;
    tick();
    start = 1'b0;
    check("len0_done_cycle", cyc == T + 1 ? longint'(done_m) : -1, 1);
    check("len0_busy", busy_m, 1);
    check("len0_csn", csn_m, 1);
    tick();
    check("len0_busy_after", busy_m, 0);
    check("len0_done_after", done_m, 0);
    repeat (10) tick();
    check("len0_csn_low_cycles", csn_low, 0);
    check("len0_done_count", done_cnt, 1);
    check("len0_rises", rises, 0);

    // Reset in the address phase aborts cleanly
    clear_mon();
    addr = 24'h00ABCD; len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    lim = 0;
    while (f_rise < 12 && lim < 1000) begin tick(); lim++; end
    resetn = 1'b0;
    #1;
    check_idle_outputs("abort");
    tick(); tick();
    resetn = 1'b1;
    repeat (20) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_csn_stays_high", csn_m, 1);
    run_txn(24'h030000, 16'd4, 1'b0, 1'b0);

    rdy_rand = 1'b1;
    repeat (6) run_txn(24'($urandom), 16'($urandom_range(1, 6)), 1'b0, 1'b0);
    rdy_rand = 1'b0; rd_ready = 1'b1;
    tick();

    sel = 1'b1;
    tick();
    run_txn(24'h050010, 16'd2, 1'b0, 1'b0);
    rdy_rand = 1'b1;
    repeat (4) run_txn(24'($urandom), 16'($urandom_range(1, 5)), 1'b0, 1'b0);
    rdy_rand = 1'b0; rd_ready = 1'b1;
    tick();

    check("mosi_contention", contention, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
